// File: rtl/id_seg_if.sv
// Bundle between the IF/WB side of the pipeline and the ID stage: incoming
// instruction, write-back port and the registered ID/EX outputs.
interface id_seg_if;
  logic [31:0] NPCi;
  logic [31:0] IR;
  logic        WBFlag;
  logic [4:0]  WBAddr;
  logic [31:0] WBVal;
  logic [31:0] NPCo;
  logic [31:0] IRo;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Imm;

  modport master (
    output NPCi, IR, WBFlag, WBAddr, WBVal,
    input  NPCo, IRo, A, B, Imm
  );

  modport slave (
    input  NPCi, IR, WBFlag, WBAddr, WBVal,
    output NPCo, IRo, A, B, Imm
  );
endinterface

// File: rtl/id_seg.sv
// Instruction-decode stage: 32x32 register file with write-through bypass,
// operand/immediate decode and the ID/EX pipeline register.
module id_seg (
  input logic     clk,
  input logic     rst,
  id_seg_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int REG_N  = 32;

  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;

  logic [DATA_W-1:0] regs [REG_N];

  logic [4:0]        rs_p0;
  logic [4:0]        rt_p0;
  logic [DATA_W-1:0] src_a_p0;
  logic [DATA_W-1:0] src_b_p0;
  logic [DATA_W-1:0] imm_p0;

  logic [DATA_W-1:0] npc_p1;
  logic [DATA_W-1:0] ir_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic [DATA_W-1:0] imm_p1;

  function automatic logic [DATA_W-1:0] ext_imm(input logic [DATA_W-1:0] ir);
    logic signed [15:0]       imm16;
    logic signed [DATA_W-1:0] sext;
    imm16 = ir[15:0];
    sext  = DATA_W'(imm16);
    case (ir[31:26])
      OP_ANDI, OP_ORI, OP_XORI: ext_imm = {16'h0, ir[15:0]};
      OP_J, OP_JAL:             ext_imm = {6'h0, ir[25:0]};
      default:                  ext_imm = sext;
    endcase
  endfunction

  // A write-back landing on the same edge must be seen by the instruction in decode.
  function automatic logic [DATA_W-1:0] read_op(
    input logic [4:0]        idx,
    input logic              wb_en,
    input logic [4:0]        wb_idx,
    input logic [DATA_W-1:0] wb_val,
    input logic [DATA_W-1:0] rf_val
  );
    if (idx == 5'd0)
      read_op = '0;
    else if (wb_en && (wb_idx == idx))
      read_op = wb_val;
    else
      read_op = rf_val;
  endfunction

  // Stage p0: combinational decode of the incoming instruction
  always_comb begin
    rs_p0    = bus.IR[25:21];
    rt_p0    = bus.IR[20:16];
    src_a_p0 = read_op(rs_p0, bus.WBFlag, bus.WBAddr, bus.WBVal, regs[rs_p0]);
    src_b_p0 = read_op(rt_p0, bus.WBFlag, bus.WBAddr, bus.WBVal, regs[rt_p0]);
    imm_p0   = ext_imm(bus.IR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++)
        regs[i] <= '0;
    end else if (bus.WBFlag && (bus.WBAddr != 5'd0)) begin
      regs[bus.WBAddr] <= bus.WBVal;
    end
  end

  // Stage p1: ID/EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      npc_p1 <= '0;
      ir_p1  <= '0;
      a_p1   <= '0;
      b_p1   <= '0;
      imm_p1 <= '0;
    end else begin
      npc_p1 <= bus.NPCi;
      ir_p1  <= bus.IR;
      a_p1   <= src_a_p0;
      b_p1   <= src_b_p0;
      imm_p1 <= imm_p0;
    end
  end

  assign bus.NPCo = npc_p1;
  assign bus.IRo  = ir_p1;
  assign bus.A    = a_p1;
  assign bus.B    = b_p1;
  assign bus.Imm  = imm_p1;
endmodule

// File: tb/tb_id_seg.sv
// Scoreboard bench for id_seg: directed cases followed by random traffic,
// checked against a register-array reference model.
module tb_id_seg;
  logic clk = 1'b0;
  logic rst;

  id_seg_if bus ();

  id_seg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] npc;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mregs [32];
  int          checks   = 0;
  int          failures = 0;
  bit          stim_done = 1'b0;

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic wf,
                                             input logic [4:0] wa, input logic [31:0] wv);
    if (idx == 0) return 32'h0;
    if (wf && wa == idx) return wv;
    return mregs[idx];
  endfunction

  function automatic logic [31:0] model_ext(input logic [31:0] ir);
    int unsigned op, imm16;
    op    = ir[31:26];
    imm16 = ir[15:0];
    if (op == 12 || op == 13 || op == 14) return imm16;
    if (op == 2 || op == 3) return ir & 32'h03FF_FFFF;
    if (imm16 >= 32'h8000) return imm16 + 32'hFFFF_0000;
    return imm16;
  endfunction

  task automatic step(input logic r, input logic [31:0] npc, input logic [31:0] ir,
                      input logic wf, input logic [4:0] wa, input logic [31:0] wv);
    exp_t e;
    rst        = r;
    bus.NPCi   = npc;
    bus.IR     = ir;
    bus.WBFlag = wf;
    bus.WBAddr = wa;
    bus.WBVal  = wv;
    if (r) begin
      e = '{default: 32'h0};
      for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    end else begin
      e.npc = npc;
      e.ir  = ir;
      e.a   = model_read(ir[25:21], wf, wa, wv);
      e.b   = model_read(ir[20:16], wf, wa, wv);
      e.imm = model_ext(ir);
      if (wf && wa != 0) mregs[wa] = wv;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one ID/EX result per clock, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("NPCo", bus.NPCo, e.npc);
        chk("IRo",  bus.IRo,  e.ir);
        chk("A",    bus.A,    e.a);
        chk("B",    bus.B,    e.b);
        chk("Imm",  bus.Imm,  e.imm);
      end
    end
  end

  initial begin
    logic [31:0] ir;
    logic [5:0]  ops [8];
    ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h02, 6'h03, 6'h23};

    step(1'b1, 32'h4, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    step(1'b0, 32'h4, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    step(1'b0, 32'h8, 32'h0000_0000, 1'b1, 5'd5, 32'h1234_5678);
    step(1'b0, 32'hC, 32'h00A5_0020, 1'b0, 5'd0, 32'h0);
    step(1'b0, 32'h10, 32'h0000_0000, 1'b1, 5'd0, 32'hDEAD_BEEF);
    step(1'b0, 32'h14, 32'h0000_0020, 1'b0, 5'd0, 32'h0);
    step(1'b0, 32'h18, 32'h0064_0020, 1'b1, 5'd3, 32'hCAFE_F00D);
    step(1'b0, 32'h1C, 32'h2001_FFFF, 1'b0, 5'd0, 32'h0);
    step(1'b0, 32'h20, 32'h3401_FFFF, 1'b0, 5'd0, 32'h0);
    step(1'b0, 32'h24, 32'h0800_0010, 1'b0, 5'd0, 32'h0);
    step(1'b0, 32'h28, 32'h0C00_8000, 1'b0, 5'd0, 32'h0);
    step(1'b0, 32'h2C, 32'h0000_0000, 1'b1, 5'd7, 32'h0000_0099);
    step(1'b1, 32'h30, 32'h0000_0000, 1'b1, 5'd7, 32'h0000_0055);
    step(1'b0, 32'h34, 32'h00E7_0020, 1'b0, 5'd0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      ir = $urandom;
      if ($urandom_range(0, 1) == 1) ir[31:26] = ops[$urandom_range(0, 7)];
      ir[25:21] = 5'($urandom_range(0, 7));
      ir[20:16] = 5'($urandom_range(0, 7));
      step($urandom_range(0, 59) == 0, $urandom, ir, $urandom_range(0, 2) != 0,
           5'($urandom_range(0, 7)), $urandom);
    end
    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_seg.md
Name: id_seg

Overview:
- Instruction-decode stage of the five-stage R/I/J-type MIPS-style pipeline, sitting between the IF stage and the EX stage.
- Contains the 32x32-bit general register file, which the WB stage writes.
- Decodes the incoming instruction into two register operands and an extended immediate.
- Latches NPC, IR, operands and immediate into the ID/EX pipeline register.

Parameters:
- none (data width 32, register count 32, fixed)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- NPCi  input  32  next-PC (PC+4) from IF stage
- IR  input  32  instruction word from IF stage
- WBFlag  input  1  register-file write enable from WB stage
- WBAddr  input  5  register-file write index
- WBVal  input  32  register-file write data
- NPCo  output  32  registered copy of NPCi
- IRo  output  32  registered copy of IR
- A  output  32  registered value of register rs = IR[25:21]
- B  output  32  registered value of register rt = IR[20:16]
- Imm  output  32  registered extended immediate

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: on a rising edge with rst=1, all 32 registers clear to 0 and NPCo, IRo, A, B, Imm all become 0. rst has priority over any simultaneous write-back.
- Register file:
  - 32 entries x 32 bits.
  - Register 0 always reads 0; writes to index 0 are ignored.
  - Write: on a rising edge with rst=0, WBFlag=1 and WBAddr!=0, reg[WBAddr] <= WBVal.
- Field decode (from IR):
  - opcode = IR[31:26]
  - rs = IR[25:21], rt = IR[20:16]
  - imm16 = IR[15:0], target26 = IR[25:0]
- Operand read with write-through bypass:
  - srcA = 0 if rs==0.
  - else srcA = WBVal if WBFlag=1 and WBAddr==rs.
  - else srcA = reg[rs].
  - srcB is identical using rt.
  - Net effect: a same-edge write-back is visible to the instruction being decoded.
- Immediate extension:
  - opcode 0x0C (andi), 0x0D (ori), 0x0E (xori): zero-extend imm16.
  - opcode 0x02 (j), 0x03 (jal): zero-extend target26.
  - all other opcodes: sign-extend imm16 (bit 15 replicated into 31:16).
- Pipeline latch:
  - Each rising edge with rst=0: NPCo<=NPCi, IRo<=IR, A<=srcA, B<=srcB, Imm<=ext.
  - Latency exactly one cycle. No stall or flush inputs; the latch updates every cycle.
- Outputs change only on clock edges; all outputs are glitch-free registers.
- Undefined or unused opcodes are still decoded per the rules above; no exception signalling.

Test Plan:
- Reset: drive NPCi=0x4, IR=0xFFFFFFFF with rst=1 for one edge -> NPCo=IRo=A=B=Imm=0; next edge with rst=0 -> NPCo=0x4, IRo=0xFFFFFFFF.
- Write then read:
  - WBFlag=1, WBAddr=5, WBVal=0x12345678, one edge.
  - Then IR=0x00A50020 (add, rs=5, rt=5).
  - Required: after next edge A=B=0x12345678.
- Register 0: write WBAddr=0, WBVal=0xDEADBEEF; then IR with rs=rt=0 -> A=B=0.
- Bypass:
  - Same edge: WBFlag=1, WBAddr=3, WBVal=0xCAFEF00D, and IR=0x00640020 (rs=3, rt=4, reg4=0).
  - Required: A=0xCAFEF00D, B=0 after that edge.
- Immediate extension:
  - IR=0x2001FFFF (addi) -> Imm=0xFFFFFFFF.
  - IR=0x3401FFFF (ori) -> Imm=0x0000FFFF.
  - IR=0x08000010 (j) -> Imm=0x00000010.
- Reset vs write: rst=1 and WBFlag=1, WBAddr=7, WBVal=0x55 on same edge; then read rs=7 -> A=0.
